uart_tx_framed: RTL and testbench
=================================

Name: uart_tx_framed

Overview:
- Parametrised UART transmitter; successor to the fixed-character, free-running TX demo.
- Serialises arbitrary words from a valid/ready source onto one TX line.
- Data width, optional parity, 1 or 2 stop bits and baud rate are configurable.
- Sits between any byte producer (FIFO, console logic) and the board UART_TX pin.

Parameters:
- CLOCK_FREQ, 125000000: sysclk frequency in Hz.
- BAUD_RATE, 115200: line rate in baud.
  - BAUD_CYCLES = CLOCK_FREQ / BAUD_RATE, integer division; 1085 at defaults.
- DATA_BITS, 8: payload bits per frame. Legal range 5..9.
- PARITY, 0: parity mode. 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: number of stop bits. Legal values 1 or 2.

Ports:
- sysclk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  DATA_BITS  word to send; sampled only on the accept cycle.
- data_in_valid  input  1  producer has a word.
- data_in_ready  output  1  block can accept a word this cycle.
- serial_out  output  1  TX line; idle high; registered.
- busy  output  1  a frame is in flight (any state other than IDLE).

Behaviour:
- Reset (synchronous, active-high): applied in any state, including mid-frame.
  - Next edge: state=IDLE, serial_out=1, busy=0, baud counter=0, bit index=0.
  - data_in_ready=0 while rst is high; 1 in the first cycle after rst deasserts.
  - A frame cut short by reset is abandoned: no completion, line returns high.
- Accept: data_in_ready = (state==IDLE) && !rst. A transfer occurs on an edge where data_in_valid && data_in_ready.
  - data_in is latched into a shift register.
  - Parity is computed from the latched word:
    - odd mode: parity bit = ~^data;
    - even mode: parity bit = ^data.
  - data_in_valid while busy is ignored and not consumed; the producer must hold it.
- Latency: serial_out drives the start bit (0) from the edge after acceptance.
- FSM states: IDLE -> START -> DATA -> PARITY (skipped when PARITY==0) -> STOP -> IDLE.
  - Each bit is held exactly BAUD_CYCLES cycles.
  - Baud counter counts 0..BAUD_CYCLES-1. Wrap to 0 advances the bit, or the state on the last bit of a state.
  - The counter restarts at 0 on acceptance.
- Bit values by state:
  - START drives 0.
  - DATA sends DATA_BITS bits, LSB first; shift register shifts right once per bit.
  - PARITY drives the parity bit.
  - STOP drives 1 for STOP_BITS bit periods.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * BAUD_CYCLES cycles.
  - Defaults: 10 * 1085 = 10850 cycles.
- Back-to-back: after the last stop-bit cycle the FSM enters IDLE.
  - With valid held, the next word is accepted in that IDLE cycle.
  - Exactly one extra idle-high cycle therefore separates frames.
- busy is 1 from the edge after acceptance until the edge entering IDLE.
- Widths:
  - Baud counter: $clog2(BAUD_CYCLES) bits.
  - Bit index: $clog2(DATA_BITS + 1) bits.
  - No arithmetic overflow is reachable.
- Illegal parameters (DATA_BITS outside 5..9, STOP_BITS not 1/2, PARITY>2, BAUD_CYCLES<2) are rejected at elaboration with a generate-time error.

Decomposition:
- Shared package/header uart_defs: PARITY_NONE=0, PARITY_ODD=1, PARITY_EVEN=2, FSM state encodings.
  - The future uart_rx reuses these.
- One sub-module, uart_baud_counter:
  - Parameter BAUD_CYCLES; inputs sysclk, rst, clear.
  - Output tick, high in the cycle the count equals BAUD_CYCLES-1.
  - Also reused by uart_rx.

Test Plan:
All directed tests run at CLOCK_FREQ=1000, BAUD_RATE=100 (BAUD_CYCLES=10) unless noted.
- Basic 8N1: send 0x41, valid pulsed 1 cycle while ready=1.
  - Required line bits, 10 cycles each: 0, 1,0,0,0,0,0,1,0, 1.
  - busy high for exactly 100 cycles.
  - ready returns 1 on cycle 101.
- Parity + 2 stop: PARITY=2, STOP_BITS=2, send 0x07 (three ones).
  - Parity bit = 1; frame is 0,1,1,1,0,0,0,0,0,1,1,1.
  - Frame length 120 cycles.
  - Repeat with PARITY=1: parity bit = 0.
- Back-to-back: valid held high with 0x55 then 0xAA.
  - Second start bit begins exactly 1 cycle after the first frame's stop bit ends.
  - Valid asserted mid-frame is not consumed.
- Reset mid-frame: assert rst for 1 cycle at cycle 35 of a 0x00 frame.
  - serial_out=1 and busy=0 on the next edge.
  - ready=1 the cycle after rst falls.
  - A new 0x3C frame then transmits correctly.
- Defaults, 7 data bits: DATA_BITS=7, default clock and baud, send 0x7F.
  - Each bit lasts exactly 1085 cycles.
  - Total frame 9765 cycles.
  - Line matches 0,1,1,1,1,1,1,1,1.

Source files
------------

// File: rtl/uart_tx_framed_pkg.sv
// Shared UART definitions: parity mode codes and FSM state encoding.
// Intended for reuse by the receive path as well.
package uart_tx_framed_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

endpackage

// File: rtl/uart_tx_framed_if.sv
// Valid/ready word stream feeding the UART transmitter.
interface uart_tx_framed_if #(
    parameter int unsigned DATA_BITS = 8
);

    logic [DATA_BITS-1:0] data_in;
    logic                 data_in_valid;
    logic                 data_in_ready;

    modport master (
        output data_in,
        output data_in_valid,
        input  data_in_ready
    );

    modport slave (
        input  data_in,
        input  data_in_valid,
        output data_in_ready
    );

endinterface

// File: rtl/uart_tx_framed_baud_counter.sv
// Free-running 0..BAUD_CYCLES-1 counter; tick marks the last cycle of a bit period.
module uart_baud_counter #(
    parameter int unsigned BAUD_CYCLES = 1085
) (
    input  logic sysclk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(BAUD_CYCLES);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign tick = (count_q == CNT_W'(BAUD_CYCLES - 1));

    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (clear || tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_framed.sv
// Parametrised UART transmitter: start, DATA_BITS LSB-first, optional parity,
// 1 or 2 stop bits, each held BAUD_CYCLES sysclk cycles.
module uart_tx_framed
    import uart_tx_framed_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 125000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic             sysclk,
    input  logic             rst,
    uart_tx_framed_if.slave  in_if,
    output logic             serial_out,
    output logic             busy
);

    localparam int unsigned BAUD_CYCLES = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned IDX_W       = $clog2(DATA_BITS + 1);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_framed: DATA_BITS must be 5..9");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
            $error("uart_tx_framed: STOP_BITS must be 1 or 2");
        end
        if (PARITY > PARITY_EVEN) begin : g_bad_parity
            $error("uart_tx_framed: PARITY must be 0, 1 or 2");
        end
        if (BAUD_CYCLES < 2) begin : g_bad_baud
            $error("uart_tx_framed: CLOCK_FREQ/BAUD_RATE must be at least 2");
        end
    endgenerate

    uart_state_e          state_q,   state_d;
    logic                 serial_q,  serial_d;
    logic                 busy_q,    busy_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic                 parity_q,  parity_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;

    logic ready;
    logic tick;

    assign ready               = (state_q == ST_IDLE) && !rst;
    assign in_if.data_in_ready = ready;
    assign serial_out          = serial_q;
    assign busy                = busy_q;

    // Held clear while idle so the first bit period starts from 0 at acceptance.
    uart_baud_counter #(
        .BAUD_CYCLES (BAUD_CYCLES)
    ) u_baud (
        .sysclk (sysclk),
        .rst    (rst),
        .clear  (state_q == ST_IDLE),
        .tick   (tick)
    );

    always_comb begin
        state_d   = state_q;
        serial_d  = serial_q;
        busy_d    = busy_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        bit_idx_d = bit_idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_if.data_in_valid && ready) begin
                    shift_d   = in_if.data_in;
                    parity_d  = (PARITY == PARITY_ODD) ? ~^in_if.data_in : ^in_if.data_in;
                    bit_idx_d = '0;
                    serial_d  = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    serial_d = shift_q[0];
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                        bit_idx_d = '0;
                        if (PARITY != PARITY_NONE) begin
                            serial_d = parity_q;
                            state_d  = ST_PARITY;
                        end else begin
                            serial_d = 1'b1;
                            state_d  = ST_STOP;
                        end
                    end else begin
                        // Look one bit ahead: the line is registered.
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        serial_d  = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    serial_d = 1'b1;
                    state_d  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (bit_idx_q == IDX_W'(STOP_BITS - 1)) begin
                        bit_idx_d = '0;
                        busy_d    = 1'b0;
                        state_d   = ST_IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                serial_d  = 1'b1;
                busy_d    = 1'b0;
                bit_idx_d = '0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            serial_q  <= 1'b1;
            busy_q    <= 1'b0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            bit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            serial_q  <= serial_d;
            busy_q    <= busy_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            bit_idx_q <= bit_idx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Directed bench for uart_tx_framed across four parameter sets, checking the line every cycle.
module tb_uart_tx_framed;

    logic       sysclk;
    logic       rst;
    logic [3:0] so_w;
    logic [3:0] busy_w;
    logic [3:0] rdy_w;

    int tests_run;
    int tests_failed;

    uart_tx_framed_if #(.DATA_BITS(8)) if0 ();
    uart_tx_framed_if #(.DATA_BITS(8)) if1 ();
    uart_tx_framed_if #(.DATA_BITS(8)) if2 ();
    uart_tx_framed_if #(.DATA_BITS(7)) if3 ();

    assign rdy_w = {if3.data_in_ready, if2.data_in_ready, if1.data_in_ready, if0.data_in_ready};

    // cfg0: 8N1, cfg1: 8E2, cfg2: 8O2 (all 10 cycles/bit); cfg3: 7N1 at default clock/baud.
    uart_tx_framed #(.CLOCK_FREQ(1000), .BAUD_RATE(100)) dut0 (
        .sysclk(sysclk), .rst(rst), .in_if(if0), .serial_out(so_w[0]), .busy(busy_w[0]));
    uart_tx_framed #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .PARITY(2), .STOP_BITS(2)) dut1 (
        .sysclk(sysclk), .rst(rst), .in_if(if1), .serial_out(so_w[1]), .busy(busy_w[1]));
    uart_tx_framed #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .PARITY(1), .STOP_BITS(2)) dut2 (
        .sysclk(sysclk), .rst(rst), .in_if(if2), .serial_out(so_w[2]), .busy(busy_w[2]));
    uart_tx_framed #(.DATA_BITS(7)) dut3 (
        .sysclk(sysclk), .rst(rst), .in_if(if3), .serial_out(so_w[3]), .busy(busy_w[3]));

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    typedef struct {
        string      name;
        int         cfg;
        logic [8:0] data;
        logic [11:0] bits;  // bit i = line level during bit period i
        int         nbits;
        int         bc;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int c, input logic v, input logic [8:0] d);
        case (c)
            0: begin if0.data_in_valid = v; if0.data_in = d[7:0]; end
            1: begin if1.data_in_valid = v; if1.data_in = d[7:0]; end
            2: begin if2.data_in_valid = v; if2.data_in = d[7:0]; end
            default: begin if3.data_in_valid = v; if3.data_in = d[6:0]; end
        endcase
    endtask

    // Present a word from a negedge; returns at the negedge after the accepting edge.
    task automatic do_accept(input int c, input logic [8:0] d, input bit hold);
        int n;
        @(negedge sysclk);
        drive(c, 1'b1, d);
        n = 0;
        while (rdy_w[c] !== 1'b1 && n < 200) begin
            @(negedge sysclk);
            n++;
        end
        if (n >= 200) check("accept timeout ready", 32'(rdy_w[c]), 32'd1);
        @(negedge sysclk);
        if (!hold) drive(c, 1'b0, d);
    endtask

    // Samples from the current negedge; one comparison per bit period covering every cycle.
    task automatic check_frame(input string name, input int c, input logic [11:0] bits,
                               input int nbits, input int bc);
        for (int b = 0; b < nbits; b++) begin
            logic [1:0] got;
            got = {1'b1, bits[b]};
            for (int k = 0; k < bc; k++) begin
                if (!(b == 0 && k == 0)) @(negedge sysclk);
                if ({busy_w[c], so_w[c]} !== {1'b1, bits[b]}) got = {busy_w[c], so_w[c]};
            end
            check($sformatf("%s bit%0d {busy,line}", name, b), 32'(got), 32'({1'b1, bits[b]}));
        end
    endtask

    task automatic check_idle_now(input string name, input int c);
        check({name, " idle line"},  32'(so_w[c]),   32'd1);
        check({name, " idle busy"},  32'(busy_w[c]), 32'd0);
        check({name, " idle ready"}, 32'(rdy_w[c]),  32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b1;
        for (int c = 0; c < 4; c++) drive(c, 1'b0, 9'h000);

        vecs[0] = '{"8N1 0x41",  0, 9'h041, 12'h282, 10, 10};
        vecs[1] = '{"8E2 0x07",  1, 9'h007, 12'hE0E, 12, 10};
        vecs[2] = '{"8O2 0x07",  2, 9'h007, 12'hC0E, 12, 10};
        vecs[3] = '{"8E2 0x03",  1, 9'h003, 12'hC06, 12, 10};
        vecs[4] = '{"8O2 0x00",  2, 9'h000, 12'hE00, 12, 10};
        vecs[5] = '{"8N1 0x55",  0, 9'h055, 12'h2AA, 10, 10};
        vecs[6] = '{"8N1 0xAA",  0, 9'h0AA, 12'h354, 10, 10};
        vecs[7] = '{"8N1 0x3C",  0, 9'h03C, 12'h278, 10, 10};
        vecs[8] = '{"7N1 0x7F",  3, 9'h07F, 12'h1FE, 9, 1085};

        // Reset state
        repeat (3) @(negedge sysclk);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("reset line c%0d", c),  32'(so_w[c]),   32'd1);
            check($sformatf("reset busy c%0d", c),  32'(busy_w[c]), 32'd0);
            check($sformatf("reset ready c%0d", c), 32'(rdy_w[c]),  32'd0);
        end
        rst = 1'b0;
        @(negedge sysclk);
        for (int c = 0; c < 4; c++)
            check($sformatf("post-reset ready c%0d", c), 32'(rdy_w[c]), 32'd1);

        // Table-driven single frames
        for (int i = 0; i < 9; i++) begin
            do_accept(vecs[i].cfg, vecs[i].data, 1'b0);
            check_frame(vecs[i].name, vecs[i].cfg, vecs[i].bits, vecs[i].nbits, vecs[i].bc);
            @(negedge sysclk);
            check_idle_now(vecs[i].name, vecs[i].cfg);
        end

        // Back-to-back with valid held; 0xAA presented mid-frame must wait
        do_accept(0, 9'h055, 1'b1);
        drive(0, 1'b1, 9'h0AA);
        check_frame("b2b first 0x55", 0, 12'h2AA, 10, 10);
        @(negedge sysclk);
        check_idle_now("b2b gap", 0);
        @(negedge sysclk);
        drive(0, 1'b0, 9'h0AA);
        check_frame("b2b second 0xAA", 0, 12'h354, 10, 10);
        @(negedge sysclk);
        check_idle_now("b2b end", 0);

        // Reset at cycle 35 of a 0x00 frame
        do_accept(0, 9'h000, 1'b0);
        repeat (35) @(negedge sysclk);
        check("midrst pre line", 32'(so_w[0]),   32'd0);
        check("midrst pre busy", 32'(busy_w[0]), 32'd1);
        rst = 1'b1;
        @(negedge sysclk);
        check("midrst line",  32'(so_w[0]),   32'd1);
        check("midrst busy",  32'(busy_w[0]), 32'd0);
        check("midrst ready", 32'(rdy_w[0]),  32'd0);
        rst = 1'b0;
        @(negedge sysclk);
        check_idle_now("midrst after", 0);
        do_accept(0, 9'h03C, 1'b0);
        check_frame("midrst 0x3C", 0, 12'h278, 10, 10);
        @(negedge sysclk);
        check_idle_now("midrst 0x3C", 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
